// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO behind a UART Rx stage: qualifies frames by low time on rx_rdy.
// Optional macro UART_RX_FIFO_OVERWRITE_EN: a push while full replaces the oldest word.
module uart_rx_fifo #(
  parameter int unsigned p_CLK_DIV  = 104,
  parameter int unsigned p_WORD_LEN = 8,
  parameter int unsigned p_DEPTH    = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [p_WORD_LEN-1:0]          i_rx_data,
  input  logic                           i_rx_rdy,
  input  logic                           i_read_en,
  input  logic                           i_ovf_clr,
  output logic [p_WORD_LEN-1:0]          o_read_data,
  output logic                           o_empty,
  output logic                           o_full,
  output logic [$clog2(p_DEPTH+1)-1:0]   o_count,
  output logic                           o_overflow
);

  localparam int unsigned p_MIN_LOW = p_CLK_DIV * p_WORD_LEN;
  localparam int unsigned LW        = $clog2(p_MIN_LOW + 1);
  localparam int unsigned AW        = $clog2(p_DEPTH);
  localparam int unsigned CW        = $clog2(p_DEPTH + 1);

  logic                  rdy_q;
  logic [LW-1:0]         low;
  logic [p_WORD_LEN-1:0] mem [p_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  logic                  rise;
  logic                  push;
  logic                  pop;
  logic                  is_full;
  logic                  ovf_evt;
  logic                  wr_en;
  logic                  adv_rd;
  logic [AW-1:0]         rd_next;
  logic [CW-1:0]         count_next;
  logic [p_WORD_LEN-1:0] head_next;

  // Push/pop decode; the new head bypasses memory when it is the word being written now
  always_comb begin
    rise    = i_rx_rdy && !rdy_q;
    push    = rise && (low == LW'(p_MIN_LOW));
    pop     = i_read_en && (o_count != '0);
    is_full = (o_count == CW'(p_DEPTH));
    ovf_evt = push && is_full && !pop;
`ifdef UART_RX_FIFO_OVERWRITE_EN
    wr_en   = push;
    adv_rd  = pop || ovf_evt;
`else
    wr_en   = push && !ovf_evt;
    adv_rd  = pop;
`endif
    rd_next    = adv_rd ? rd_ptr + AW'(1) : rd_ptr;
    count_next = o_count + CW'(wr_en) - CW'(adv_rd);
    head_next  = (wr_en && (wr_ptr == rd_next)) ? i_rx_data : mem[rd_next];
  end

  // Frame qualification: count low cycles, saturating at the threshold
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdy_q <= 1'b1;
      low   <= '0;
    end else begin
      rdy_q <= i_rx_rdy;
      if (rise)
        low <= '0;
      else if (!i_rx_rdy && (low != LW'(p_MIN_LOW)))
        low <= low + LW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wr_ptr] <= i_rx_data;
  end

  // Pointers, occupancy and registered status
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_count     <= '0;
      o_empty     <= 1'b1;
      o_full      <= 1'b0;
      o_overflow  <= 1'b0;
      o_read_data <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_next;
      o_count <= count_next;
      o_empty <= (count_next == '0);
      o_full  <= (count_next == CW'(p_DEPTH));
      if (wr_en || adv_rd)
        o_read_data <= head_next;
      if (ovf_evt)
        o_overflow <= 1'b1;
      else if (i_ovf_clr)
        o_overflow <= 1'b0;
    end
  end

endmodule
